// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with per-beat sideband storage, cut-through or store-and-forward output,
// and a deadlock release that lets a packet larger than the buffer drain in store-and-forward mode.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic [DATA_WIDTH/8-1:0]   s_keep,
    input  logic                      s_last,
    input  logic [DEST_WIDTH-1:0]     s_dest,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [DATA_WIDTH/8-1:0]   m_keep,
    output logic                      m_last,
    output logic [DEST_WIDTH-1:0]     m_dest,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    pkt_count,
    output logic                      oversize
);

    localparam int AW       = $clog2(DEPTH);
    localparam int KW       = DATA_WIDTH / 8;
    localparam int LAST_BIT = DATA_WIDTH + KW;
    localparam int BW       = LAST_BIT + 1 + DEST_WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [BW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [AW:0]   pkt_count_reg;
    logic [AW:0]   pkt_count_next;
    logic          s_ready_reg;
    logic          s_ready_next;
    logic          release_reg;
    logic          release_next;
    logic          oversize_reg;
    logic          oversize_next;
    logic          bypass_sel_reg;
    logic          bypass_sel_next;

    logic [BW-1:0] s_beat;
    logic [BW-1:0] ram_q_reg;
    logic [BW-1:0] bypass_reg;
    logic [BW-1:0] head;
    logic [BW-1:0] head_out;
    logic          head_last;
    logic          m_valid_int;
    logic          wr_en;
    logic          rd_en;
    logic          wr_last;
    logic          rd_last;

    assign s_beat    = {s_dest, s_last, s_keep, s_data};
    assign s_ready   = s_ready_reg && !rst;
    assign wr_en     = s_valid && s_ready;
    assign m_valid   = m_valid_int && !rst;
    assign rd_en     = m_valid && m_ready;
    assign wr_last   = wr_en && s_last;
    assign rd_last   = rd_en && head_last;

    // The RAM is read one cycle ahead at the address the head will occupy next cycle;
    // a beat written into that same slot is forwarded from a side register instead.
    assign rd_addr         = rd_ptr_reg + AW'(rd_en);
    assign bypass_sel_next = wr_en && (wr_ptr_reg == rd_addr);

    assign head      = bypass_sel_reg ? bypass_reg : ram_q_reg;
    assign head_last = head[LAST_BIT];
    assign head_out  = rst ? '0 : head;

    genvar gi;
    for (gi = 0; gi < KW; gi++) begin : g_lane
        assign m_data[gi*8 +: 8] = head_out[gi*8 +: 8];
        assign m_keep[gi]        = head_out[DATA_WIDTH + gi];
    end
    assign m_last = head_out[LAST_BIT];
    assign m_dest = head_out[BW-1 -: DEST_WIDTH];

    if (PACKET_MODE != 0) begin : g_store_forward
        assign m_valid_int = (count_reg != '0) && ((pkt_count_reg != '0) || release_reg);
    end else begin : g_cut_through
        assign m_valid_int = (count_reg != '0);
    end

    assign count     = count_reg;
    assign pkt_count = pkt_count_reg;
    assign oversize  = oversize_reg;

    always_comb begin
        count_next     = count_reg;
        pkt_count_next = pkt_count_reg;
        release_next   = release_reg;
        oversize_next  = oversize_reg;

        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        case ({wr_last, rd_last})
            2'b10:   pkt_count_next = pkt_count_reg + 1'b1;
            2'b01:   pkt_count_next = pkt_count_reg - 1'b1;
            default: pkt_count_next = pkt_count_reg;
        endcase

        // A full buffer with no complete packet can never make progress on its own.
        if ((PACKET_MODE != 0) && (count_reg == FULL_COUNT) && (pkt_count_reg == '0)) begin
            release_next  = 1'b1;
            oversize_next = 1'b1;
        end else if (rd_last) begin
            release_next = 1'b0;
        end

        s_ready_next = (count_next < FULL_COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            pkt_count_reg  <= '0;
            s_ready_reg    <= 1'b1;
            release_reg    <= 1'b0;
            oversize_reg   <= 1'b0;
            bypass_sel_reg <= 1'b0;
            bypass_reg     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg     <= rd_addr;
            count_reg      <= count_next;
            pkt_count_reg  <= pkt_count_next;
            s_ready_reg    <= s_ready_next;
            release_reg    <= release_next;
            oversize_reg   <= oversize_next;
            bypass_sel_reg <= bypass_sel_next;
            bypass_reg     <= s_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= s_beat;
        end
        ram_q_reg <= mem[rd_addr];
    end

endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning tdata width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEST_WIDTH, default 1, meaning tdest width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning storage entries; legal values are powers of 2 that are at least 4.
REQ-004 SHALL have parameter PACKET_MODE, default 0, meaning 1 = store-and-forward and 0 = cut-through.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports s_valid input 1, s_ready output 1, s_data input DATA_WIDTH, s_keep input DATA_WIDTH/8, s_last input 1, s_dest input DEST_WIDTH: the AXIS slave.
REQ-008 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_WIDTH, m_keep output DATA_WIDTH/8, m_last output 1, m_dest output DEST_WIDTH: the AXIS master.
REQ-009 SHALL have port count, output, log2(DEPTH)+1 bits: words held, including the word presented on the master side.
REQ-010 SHALL have port pkt_count, output, log2(DEPTH)+1 bits: complete packets held, i.e. stored words with last=1.
REQ-011 SHALL have port oversize, output 1 bit: sticky flag set when a packet-mode deadlock release occurs.

Function
REQ-012 SHALL accept a beat when s_valid && s_ready and release a beat when m_valid && m_ready (the "write" and "read" events below).
REQ-013 SHALL drive s_ready = (count < DEPTH), registered and independent of m_ready in the same cycle.
REQ-014 SHALL store data, keep, last and dest together per entry and emit them unchanged, in order.
REQ-015 SHALL present a beat written in cycle N on the master side no earlier than cycle N+1; there is no combinational s->m path.
REQ-016 SHALL hold m_data, m_keep, m_last and m_dest stable, and keep m_valid asserted, while m_valid && !m_ready.
REQ-017 SHALL update count by +1 on a write only, -1 on a read only, and 0 on a simultaneous write and read.
REQ-018 SHALL block writes when full even if a read occurs in the same cycle; s_ready rises in the cycle after the read.
REQ-019 SHALL update pkt_count by +1 on a write with s_last=1, -1 on a read with m_last=1, and 0 when both occur together.
REQ-020 SHALL, when PACKET_MODE=0, assert m_valid whenever count > 0.
REQ-021 SHALL, when PACKET_MODE=1, assert m_valid only when count > 0 and (pkt_count > 0 or the release flag is set).
REQ-022 SHALL, when PACKET_MODE=1 and count == DEPTH and pkt_count == 0, set the release flag and set oversize.
REQ-023 SHALL clear the release flag on the read of a beat with last=1.
REQ-024 SHALL hold oversize set until rst.
REQ-025 SHALL implement read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH with no gap or duplicate entry.
REQ-026 SHALL ignore s_data, s_keep, s_last and s_dest when s_valid=0, and ignore m_ready when m_valid=0.

Reset
REQ-027 SHALL, during any cycle with rst=1, clear both pointers, count, pkt_count, the release flag and oversize, and drive m_valid=0 and s_ready=0.
REQ-028 SHALL drive s_ready=1 in the first cycle after rst is deasserted.
REQ-029 SHALL, when rst is asserted mid-packet, discard all stored beats; no partial packet is emitted after reset.
REQ-030 SHALL drive m_data, m_keep, m_last and m_dest to 0 during reset.

Verification
REQ-031 SHALL cover cut-through: DEPTH=16, PACKET_MODE=0, one beat 0xA5 with last=1 and m_ready=1 -> m_valid rises the next cycle with m_data=0xA5, and count goes 1 then 0.
REQ-032 SHALL cover full: 16 writes with m_ready=0 -> s_ready=0 and count=16; one read -> s_ready=1 the following cycle, never earlier.
REQ-033 SHALL cover store-and-forward: PACKET_MODE=1, 5-beat packet with last on beat 5 -> m_valid stays 0 until the cycle after beat 5 is accepted, then 5 beats leave in order.
REQ-034 SHALL cover oversize: PACKET_MODE=1, a 20-beat packet into DEPTH=16 -> oversize=1, the first 16 beats drain, and all 20 beats leave intact.
REQ-035 SHALL cover simultaneous events and wrap: continuous write+read for 40 beats with random m_ready -> count never exceeds 16, the pointers wrap, and data order is preserved.
REQ-036 SHALL cover reset mid-operation: rst at count=7 and pkt_count=1 -> count=0, pkt_count=0 and m_valid=0 next cycle, with no stale beat emitted afterwards.
